// File: rtl/float_struct.sv
// Shared types and constants for the FPU normalize/pack back end.
package float_struct;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_NAN = 2'b01,
    ST_INF = 2'b10,
    ST_NUL = 2'b11
  } float_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
  } float_raw_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          EXP_MAX = 255;
  localparam int          BIAS    = 127;

endpackage

// File: rtl/lzc28.sv
// 28-bit leading-zero counter; an all-zero input reports a count of 28.
module lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Scan from the LSB up so the highest set bit writes the count last.
  always_comb begin
    count    = 5'd28;
    all_zero = (value == 28'd0);
    for (int i = 0; i <= 27; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/float_normalize_pack.sv
// Normalize, round-to-nearest-even and pack the raw adder sum into an
// IEEE-754 single, three register stages, one sample per cycle.
module float_normalize_pack
  import float_struct::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arg_vld,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [1:0]        in_state,
  output logic [31:0]       result,
  output logic [1:0]        state,
  output logic              res_vld
);

  logic [STAGES-1:0] vld_sr;

  // Stage 1 registers
  float_raw_t  s1_raw;
  logic [1:0]  s1_state;
  logic [4:0]  s1_lz;
  logic        s1_zero;

  // Stage 2 registers: bit 26 of s2_mant is the hidden one after normalize
  logic              s2_sign;
  logic signed [9:0] s2_exp;
  logic [26:0]       s2_mant;
  logic [1:0]        s2_state;
  logic              s2_zero;

  // Output registers
  logic [31:0]  result_q;
  float_state_t state_q;

  // Leading zeros below the carry bit: count over the full word, then drop
  // the carry position; an all-zero mantissa yields 27.
  logic [4:0] lz_full;
  logic       mant_zero;
  logic [4:0] lz_in;

  lzc28 u_lzc (
    .value    (in_mant),
    .count    (lz_full),
    .all_zero (mant_zero)
  );

  assign lz_in = in_mant[27] ? 5'd0 : (lz_full - 5'd1);

  // Valid bits travel alongside the data; reset empties the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= {vld_sr[STAGES-2:0], arg_vld};
  end

  // Stage 1 captures the raw sample plus its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_raw   <= '0;
      s1_state <= ST_NUL;
      s1_lz    <= '0;
      s1_zero  <= 1'b1;
    end else begin
      s1_raw   <= '{sign: in_sign, exp: in_exp, mant: in_mant};
      s1_state <= in_state;
      s1_lz    <= lz_in;
      s1_zero  <= mant_zero;
    end
  end

  // Normalize: a carry shifts right once folding the lost bit into sticky,
  // otherwise shift left until the hidden bit is set.
  logic [27:0]       norm_mant;
  logic signed [9:0] norm_exp;

  always_comb begin
    norm_mant = s1_raw.mant << s1_lz;
    norm_exp  = $signed({2'b00, s1_raw.exp}) - $signed({5'd0, s1_lz});
    if (s1_raw.mant[27]) begin
      norm_mant = {1'b0, s1_raw.mant[27:2], s1_raw.mant[1] | s1_raw.mant[0]};
      norm_exp  = $signed({2'b00, s1_raw.exp}) + 10'sd1;
    end
  end

  // Stage 2 holds the normalized mantissa and signed exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_mant  <= '0;
      s2_state <= ST_NUL;
      s2_zero  <= 1'b1;
    end else begin
      s2_sign  <= s1_raw.sign;
      s2_exp   <= norm_exp;
      s2_mant  <= norm_mant[26:0];
      s2_state <= s1_state;
      s2_zero  <= s1_zero;
    end
  end

  // Round to nearest even on G/R/S, renormalize a rounding carry, classify.
  logic              round_up;
  logic [24:0]       sum25;
  logic [22:0]       frac;
  logic signed [9:0] exp3;
  logic [31:0]       result_d;
  float_state_t      state_d;

  always_comb begin
    round_up = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
    sum25    = {1'b0, s2_mant[26:3]} + {24'd0, round_up};
    frac     = sum25[24] ? sum25[23:1] : sum25[22:0];
    exp3     = s2_exp + $signed({9'd0, sum25[24]});
    result_d = {s2_sign, exp3[7:0], frac};
    state_d  = ST_OK;
    if (s2_state == ST_NAN) begin
      result_d = QNAN;
      state_d  = ST_NAN;
    end else if (s2_state == ST_INF) begin
      result_d = {s2_sign, 8'hFF, 23'd0};
      state_d  = ST_INF;
    end else if (s2_zero || exp3 <= 10'sd0) begin
      result_d = 32'd0;
      state_d  = ST_NUL;
    end else if (exp3 >= 10'(EXP_MAX)) begin
      result_d = {s2_sign, 8'hFF, 23'd0};
      state_d  = ST_INF;
    end
  end

  // Outputs change only when a valid sample leaves the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      state_q  <= ST_NUL;
    end else if (vld_sr[STAGES-2]) begin
      result_q <= result_d;
      state_q  <= state_d;
    end
  end

  assign result  = result_q;
  assign state   = state_q;
  assign res_vld = vld_sr[STAGES-1];

endmodule
